// File: rtl/gf16_inv_if.sv
// ---------------------------------------------------------------------------
// gf16_inv_if
// Stream bundle for the composite-field inverter: one 8-bit input channel and
// one 8-bit output channel, each with valid/ready flow control.
//
//   in_valid   producer -> inverter   in_data valid
//   in_ready   inverter -> producer   input stage can accept this cycle
//   in_data    producer -> inverter   mapped element, [7:4]=ah, [3:0]=al
//   out_valid  inverter -> consumer   out_data valid
//   out_ready  consumer -> inverter   consumer accepts this cycle
//   out_data   inverter -> consumer   inverse, [7:4]=ah', [3:0]=al'
//
// Modports: slave = the inverter, master = the environment driving it.
// ---------------------------------------------------------------------------
interface gf16_inv_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/gf16_inv_pipe.sv
// ---------------------------------------------------------------------------
// gf16_inv_pipe
// Pipelined multiplicative inverter over GF((2^4)^2), sitting between the
// GF(2^8)->GF(2^4)^2 isomorphic map and the inverse map / affine stage of a
// composite-field AES S-box.
//
//   GF(2^4): x^4 + x + 1.  Extension: y^2 + y + lambda, lambda = 4'hE.
//   d   = lambda*ah^2 ^ ah*al ^ al^2
//   d'  = d^-1 (0^-1 = 0)
//   ah' = ah*d'
//   al' = (ah^al)*d'
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    gf16_inv_if.slave (in_valid/in_ready/in_data,
//                             out_valid/out_ready/out_data)
//
// Build option: define GF16_INV_STAGE2_EN to add a register stage holding
// ah, al and d' between S1 and the output stage (latency 3, capacity 3).
// Without it d' is looked up combinationally (latency 2, capacity 2).
// Results are identical in both builds.
//
// Every stage carries a valid bit and loads whenever it is empty or its
// contents leave in the same cycle, so bubbles collapse under backpressure.
// ---------------------------------------------------------------------------
module gf16_inv_pipe (
  input  logic       clk,
  input  logic       rst_n,
  gf16_inv_if.slave  bus
);

  localparam logic [3:0] LAMBDA = 4'hE;

  // GF(2^4) multiply, reduction by x^4 + x + 1 (x^4 folds back to 4'h3).
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // GF(2^4) inverse table; 0 maps to 0.
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] r;
    case (a)
      4'h0: r = 4'h0;
      4'h1: r = 4'h1;
      4'h2: r = 4'h9;
      4'h3: r = 4'hE;
      4'h4: r = 4'hD;
      4'h5: r = 4'hB;
      4'h6: r = 4'h7;
      4'h7: r = 4'h6;
      4'h8: r = 4'hF;
      4'h9: r = 4'h2;
      4'hA: r = 4'hC;
      4'hB: r = 4'h5;
      4'hC: r = 4'hA;
      4'hD: r = 4'h4;
      4'hE: r = 4'h3;
      default: r = 4'h8;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Input-side arithmetic: norm d of the incoming element.
  // ---------------------------------------------------------------------
  logic [3:0] in_ah;
  logic [3:0] in_al;
  logic [3:0] in_d;

  assign in_ah = bus.in_data[7:4];
  assign in_al = bus.in_data[3:0];
  assign in_d  = gf16_mul(LAMBDA, gf16_mul(in_ah, in_ah))
               ^ gf16_mul(in_ah, in_al)
               ^ gf16_mul(in_al, in_al);

  // ---------------------------------------------------------------------
  // Stage registers and flow control.
  // ---------------------------------------------------------------------
  logic       s1_valid;
  logic [3:0] s1_ah;
  logic [3:0] s1_al;
  logic [3:0] s1_d;

  logic       so_valid;
  logic [7:0] so_data;

  // Output stage can take new data when empty or when its word leaves now.
  logic so_load;
  assign so_load = !so_valid || bus.out_ready;

  // Operands presented to the output stage.
  logic       up_valid;
  logic [3:0] up_ah;
  logic [3:0] up_al;
  logic [3:0] up_dinv;

  logic       s1_load;
  assign s1_load = bus.in_valid && bus.in_ready;

`ifdef GF16_INV_STAGE2_EN
  logic       s2_valid;
  logic [3:0] s2_ah;
  logic [3:0] s2_al;
  logic [3:0] s2_dinv;
  logic       s2_load;

  assign s2_load      = !s2_valid || so_load;
  assign bus.in_ready = !s1_valid || s2_load;

  assign up_valid = s2_valid;
  assign up_ah    = s2_ah;
  assign up_al    = s2_al;
  assign up_dinv  = s2_dinv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s2_load && s1_valid) begin
      s2_ah   <= s1_ah;
      s2_al   <= s1_al;
      s2_dinv <= gf16_inv(s1_d);
    end
  end
`else
  assign bus.in_ready = !s1_valid || so_load;

  assign up_valid = s1_valid;
  assign up_ah    = s1_ah;
  assign up_al    = s1_al;
  assign up_dinv  = gf16_inv(s1_d);
`endif

  // ---------------------------------------------------------------------
  // S1: valid bit under reset, payload captured only on accept.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
    end
  end

  // NOTE: payload registers carry no reset; their contents are meaningless
  // while the matching valid bit is low, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_ah <= in_ah;
      s1_al <= in_al;
      s1_d  <= in_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output stage: out_data must read 8'h00 out of reset, so it is reset.
  // Holds its word whenever out_valid && !out_ready.
  // ---------------------------------------------------------------------
  logic [3:0] res_ah;
  logic [3:0] res_al;

  assign res_ah = gf16_mul(up_ah, up_dinv);
  assign res_al = gf16_mul(up_ah ^ up_al, up_dinv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      so_valid <= 1'b0;
      so_data  <= 8'h00;
    end else if (so_load) begin
      so_valid <= up_valid;
      if (up_valid) so_data <= {res_ah, res_al};
    end
  end

  assign bus.out_valid = so_valid;
  assign bus.out_data  = so_data;

endmodule

// File: tb/tb_gf16_inv_pipe.sv
// ---------------------------------------------------------------------------
// tb_gf16_inv_pipe
// Self-checking bench for gf16_inv_pipe. The reference inverse table is
// built by exhaustive search over GF((2^4)^2) multiplication, and every
// accepted item is queued with its expected result; deliveries pop the queue
// in order. Inputs are driven on the falling edge and outputs sampled 1 time
// unit later, which also gives the handshake decision for the next rising
// edge. Latency is counted with the cycle in which the item is offered and
// accepted as cycle 0.
// ---------------------------------------------------------------------------
module tb_gf16_inv_pipe;

`ifdef GF16_INV_STAGE2_EN
  localparam int LAT = 3;
  localparam int CAP = 3;
`else
  localparam int LAT = 2;
  localparam int CAP = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  gf16_inv_if bus ();

  gf16_inv_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard state
  logic [7:0] ref_inv [256];
  logic [7:0] exp_q [$];
  int         n_acc = 0;
  int         n_dlv = 0;
  logic       held_valid = 1'b0;
  logic [7:0] held_data  = 8'h00;

  // ---------------- reference arithmetic ----------------
  function automatic logic [3:0] f16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] poly;
    p = 8'h00;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ ({4'h0, a} << i);
    for (int k = 7; k >= 4; k--) begin
      poly = 8'h13 << (k - 4);
      if (p[k]) p = p ^ poly;
    end
    return p[3:0];
  endfunction

  // (a1*y + a0)(b1*y + b0) with y^2 = y + 4'hE
  function automatic logic [7:0] f256_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    logic [3:0] hi;
    logic [3:0] lo;
    hh = f16_mul(a[7:4], b[7:4]);
    hi = hh ^ f16_mul(a[7:4], b[3:0]) ^ f16_mul(a[3:0], b[7:4]);
    lo = f16_mul(hh, 4'hE) ^ f16_mul(a[3:0], b[3:0]);
    return {hi, lo};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs, update the scoreboard.
  task automatic step(input logic v, input logic [7:0] d, input logic r,
                      output logic acc, output logic dlv, output logic [7:0] dq);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    if (held_valid) begin
      check("stall_valid_hold", bus.out_valid, 1);
      check("stall_data_hold", bus.out_data, held_data);
    end
    held_valid = bus.out_valid && !r;
    held_data  = bus.out_data;
    dlv = bus.out_valid && r;
    dq  = bus.out_data;
    if (dlv) begin
      check("no_dup_output", n_dlv < n_acc, 1);
      if (exp_q.size() > 0) check("order_data", dq, exp_q.pop_front());
      n_dlv++;
    end
    acc = v && bus.in_ready;
    if (acc) begin
      exp_q.push_back(ref_inv[d]);
      n_acc++;
    end
  endtask

  task automatic drain(input string tag);
    logic a, dv;
    logic [7:0] q;
    for (int i = 0; i < 20 && n_dlv < n_acc; i++) step(1'b0, 8'h00, 1'b1, a, dv, q);
    check(tag, n_dlv, n_acc);
  endtask

  task automatic clear_model();
    exp_q.delete();
    n_acc = 0;
    n_dlv = 0;
    held_valid = 1'b0;
  endtask

  // Watchdog: the stimulus loops are bounded, this only guards a hang.
  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       acc, dlv;
    logic [7:0] dq;
    logic [7:0] vec [3];
    logic [7:0] known_in [3];
    logic [7:0] known_out [3];
    logic [7:0] drain_exp [3];
    int idx, dcnt, sent, base;
    logic [7:0] z;

    // Reference inverse table by search.
    ref_inv[0] = 8'h00;
    for (int x = 1; x < 256; x++) begin
      ref_inv[x] = 8'h00;
      for (int y = 1; y < 256; y++) begin
        z = 8'(y);
        if (f256_mul(8'(x), z) == 8'h01) ref_inv[x] = z;
      end
    end

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // ---------------- power-on reset ----------------
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_in_ready", bus.in_ready, 1);

    // ---------------- known vectors with latency ----------------
    known_in[0] = 8'h00; known_out[0] = 8'h00;
    known_in[1] = 8'h01; known_out[1] = 8'h01;
    known_in[2] = 8'h10; known_out[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, known_in[i], 1'b1, acc, dlv, dq);
      check("known_accept", acc, 1);
      for (int k = 1; k <= LAT; k++) begin
        step(1'b0, 8'h00, 1'b1, acc, dlv, dq);
        check("known_latency_valid", bus.out_valid, (k == LAT));
        if (k == LAT) check("known_data", dq, known_out[i]);
      end
    end

    // ---------------- exhaustive back-to-back ----------------
    for (int c = 0; c < 256 + LAT; c++) begin
      step(c < 256, 8'(c), 1'b1, acc, dlv, dq);
      if (c < 256) check("ex_accept", acc, 1);
      check("ex_out_valid", bus.out_valid, (c >= LAT));
      if (dlv && (c - LAT) != 0) check("ex_inverse_product", f256_mul(8'(c - LAT), dq), 8'h01);
    end
    check("ex_count", n_dlv, n_acc);

    // ---------------- backpressure ----------------
    vec[0] = 8'h10; vec[1] = 8'h01; vec[2] = 8'h00;
    drain_exp[0] = 8'h33; drain_exp[1] = 8'h01; drain_exp[2] = 8'h00;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(idx < 3, vec[idx < 3 ? idx : 0], 1'b0, acc, dlv, dq);
      check("bp_in_ready", bus.in_ready, (c < CAP));
      check("bp_out_valid", bus.out_valid, (c >= LAT));
      if (c >= LAT) check("bp_hold_33", bus.out_data, 8'h33);
      if (acc) idx++;
    end
    check("bp_accepted", idx, CAP);
    dcnt = 0;
    for (int c = 0; c < 12 && dcnt < 3; c++) begin
      step(idx < 3, vec[idx < 3 ? idx : 0], 1'b1, acc, dlv, dq);
      if (acc) idx++;
      if (dlv) begin
        check("bp_drain_order", dq, drain_exp[dcnt]);
        dcnt++;
      end
    end
    check("bp_drain_count", dcnt, 3);

    // ---------------- bubble collapse ----------------
    step(1'b1, 8'h01, 1'b0, acc, dlv, dq);
    check("bub_accept_first", acc, 1);
    step(1'b0, 8'h00, 1'b0, acc, dlv, dq);
    check("bub_idle_in_ready", bus.in_ready, 1);
    step(1'b1, 8'h10, 1'b0, acc, dlv, dq);
    check("bub_accept_second", acc, 1);
    drain("bub_drain");

    // ---------------- reset mid-stream ----------------
    for (int c = 0; c < 4; c++) step(1'b1, 8'($urandom), 1'b0, acc, dlv, dq);
    check("mid_full_in_ready", bus.in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_data", bus.out_data, 8'h00);
    check("mid_rst_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b0;
    clear_model();
    @(negedge clk);
    #1;
    check("mid_rst_held_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    #1;
    check("mid_rel_out_valid", bus.out_valid, 0);
    check("mid_rel_out_data", bus.out_data, 8'h00);
    check("mid_rel_in_ready", bus.in_ready, 1);

    // ---------------- random traffic ----------------
    sent = 0;
    base = n_dlv;
    for (int c = 0; c < 50000 && (n_dlv - base) < 10000; c++) begin
      step((sent < 10000) && 1'($urandom), 8'($urandom), 1'($urandom), acc, dlv, dq);
      if (acc) sent++;
    end
    check("rand_delivered", n_dlv - base, 10000);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
